// File: rtl/asic_oa_pipe.sv
// rtl/asic_oa_pipe.sv - two-stage pipelined masked OR-AND / AND-OR reduction with valid/ready handshake
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   in_valid   input word valid
//   in_ready   block accepts the input word this cycle
//   in_data    operand bits, group g at [g*WIDTH +: WIDTH]
//   in_mask    1 = bit participates, 0 = bit ignored
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out_z      combined result of all groups
//   out_group  per-group reduction results belonging to out_z
module asic_oa_pipe #(
   parameter int    GROUPS = 3,
   parameter int    WIDTH  = 2,
   parameter string MODE   = "OA",
   parameter string PROP   = "DEFAULT"
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [GROUPS*WIDTH-1:0] in_data,
   input  logic [GROUPS*WIDTH-1:0] in_mask,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    out_z,
   output logic [GROUPS-1:0]       out_group
);

   localparam bit IsAo = (MODE == "AO");

   if (MODE != "OA" && MODE != "AO") begin : g_bad_mode
      $error("asic_oa_pipe: MODE must be OA or AO");
   end
   if (GROUPS < 1 || WIDTH < 1) begin : g_bad_size
      $error("asic_oa_pipe: GROUPS and WIDTH must be at least 1");
   end
   if (PROP == "") begin : g_bad_prop
      $error("asic_oa_pipe: PROP must not be empty");
   end

   logic              s1_valid_q, s1_valid_d;
   logic [GROUPS-1:0] grp_q, grp_d, grp_new;
   logic              out_valid_q, out_valid_d;
   logic              out_z_q, out_z_d;
   logic [GROUPS-1:0] out_group_q, out_group_d;

   logic ready2, ready1, in_xfer, adv2;

   // A stage can take new data when it is empty or its content leaves this cycle.
   assign ready2   = !out_valid_q || out_ready;
   assign ready1   = !s1_valid_q || ready2;
   assign in_xfer  = in_valid && ready1;
   assign adv2     = s1_valid_q && ready2;
   assign in_ready = ready1;

   // Per-group reduction of the incoming word. A fully masked group yields the
   // neutral element of the final combine (1 for AND, 0 for OR).
   always_comb begin
      logic [WIDTH-1:0] gd;
      logic [WIDTH-1:0] gm;
      grp_new = '0;
      gd      = '0;
      gm      = '0;
      for (int g = 0; g < GROUPS; g++) begin
         gd = in_data[g*WIDTH +: WIDTH];
         gm = in_mask[g*WIDTH +: WIDTH];
         if (IsAo) begin
            grp_new[g] = (|gm) && (&(gd | ~gm));
         end else begin
            grp_new[g] = (~|gm) || (|(gd & gm));
         end
      end
   end

   always_comb begin
      s1_valid_d  = s1_valid_q;
      grp_d       = grp_q;
      out_valid_d = out_valid_q;
      out_z_d     = out_z_q;
      out_group_d = out_group_q;

      if (in_xfer) begin
         s1_valid_d = 1'b1;
         grp_d      = grp_new;
      end else if (adv2) begin
         s1_valid_d = 1'b0;
      end

      if (adv2) begin
         out_valid_d = 1'b1;
         out_group_d = grp_q;
         out_z_d     = IsAo ? (|grp_q) : (&grp_q);
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid_q  <= 1'b0;
         grp_q       <= '0;
         out_valid_q <= 1'b0;
         out_z_q     <= 1'b0;
         out_group_q <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         grp_q       <= grp_d;
         out_valid_q <= out_valid_d;
         out_z_q     <= out_z_d;
         out_group_q <= out_group_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_z     = out_z_q;
   assign out_group = out_group_q;

endmodule
